// File: rtl/mole_spawner.sv
// Mole initiator for the whack-a-mole game: picks a random LED, times its
// lifetime, and reports hit / miss / wrong-button strobes and the miss count.
module mole_spawner #(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned GAP_TIME   = 200,
  parameter int unsigned MOLE_TIME  = 800,
  parameter int unsigned MISS_LIMIT = 10,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       EN,
  input  logic [7:0] btn_pulse,
  output logic [7:0] LEDs,
  output logic       mole_valid,
  output logic [2:0] mole_idx,
  output logic       hit_strobe,
  output logic       miss_strobe,
  output logic       wrong_strobe,
  output logic [3:0] miss_cnt,
  output logic       game_over
);

  localparam int unsigned PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned T_MAX = (GAP_TIME > MOLE_TIME) ? GAP_TIME : MOLE_TIME;
  localparam int unsigned TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TIME - 1);
  localparam logic [TW-1:0] MOLE_LAST  = TW'(MOLE_TIME - 1);
  localparam logic [3:0]    LIMIT      = 4'(MISS_LIMIT);
  localparam logic [7:0]    SEED_EFF   = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_UP   = 2'd2,
    S_OVER = 2'd3
  } state_t;

  // x^8+x^6+x^5+x^4+1: feedback is the parity of bits 7,5,4,3
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [TW-1:0] r_tcnt;
  logic [7:0]    r_lfsr;
  logic [7:0]    r_leds;
  logic          r_valid;
  logic [2:0]    r_mole_idx;
  logic          r_hit;
  logic          r_miss;
  logic          r_wrong;
  logic [3:0]    r_miss_cnt;
  logic          r_over;

  logic          w_tick;
  logic [2:0]    w_cand;
  logic [2:0]    w_next_idx;
  logic [7:0]    w_next_leds;
  logic          w_hit;
  logic          w_gap_done;
  logic          w_timeout;
  logic [3:0]    w_miss_next;

  assign w_tick      = (r_presc == PRESC_LAST);
  assign w_cand      = r_lfsr[2:0];
  assign w_next_idx  = (w_cand == r_mole_idx) ? (w_cand + 3'd1) : w_cand;
  assign w_next_leds = ~(8'b0000_0001 << w_next_idx);
  assign w_hit       = btn_pulse[r_mole_idx];
  assign w_gap_done  = w_tick && (r_tcnt == GAP_LAST);
  assign w_timeout   = w_tick && (r_tcnt == MOLE_LAST);
  assign w_miss_next = (r_miss_cnt >= LIMIT) ? LIMIT : (r_miss_cnt + 4'd1);

  // Game FSM with timers, LFSR and all registered outputs
  always_ff @(posedge Clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_presc    <= '0;
      r_tcnt     <= '0;
      r_lfsr     <= SEED_EFF;
      r_leds     <= 8'hFF;
      r_valid    <= 1'b0;
      r_mole_idx <= 3'd0;
      r_hit      <= 1'b0;
      r_miss     <= 1'b0;
      r_wrong    <= 1'b0;
      r_miss_cnt <= 4'd0;
      r_over     <= 1'b0;
    end else begin
      r_lfsr  <= lfsr_next(r_lfsr);
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
      r_wrong <= 1'b0;
      if (w_tick) begin
        r_presc <= '0;
        r_tcnt  <= r_tcnt + TW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      // Dropping EN wins over any hit or timeout decided this cycle
      if (!EN) begin
        r_state    <= S_IDLE;
        r_presc    <= '0;
        r_tcnt     <= '0;
        r_leds     <= 8'hFF;
        r_valid    <= 1'b0;
        r_miss_cnt <= 4'd0;
        r_over     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_GAP;
            r_presc <= '0;
            r_tcnt  <= '0;
            r_leds  <= 8'hFF;
            r_valid <= 1'b0;
          end
          S_GAP: begin
            if (w_gap_done) begin
              r_state    <= S_UP;
              r_presc    <= '0;
              r_tcnt     <= '0;
              r_mole_idx <= w_next_idx;
              r_leds     <= w_next_leds;
              r_valid    <= 1'b1;
            end else begin
              r_leds  <= 8'hFF;
              r_valid <= 1'b0;
            end
          end
          S_UP: begin
            if (w_hit) begin
              r_hit   <= 1'b1;
              r_state <= S_GAP;
              r_presc <= '0;
              r_tcnt  <= '0;
              r_leds  <= 8'hFF;
              r_valid <= 1'b0;
            end else begin
              r_wrong <= |btn_pulse;
              if (w_timeout) begin
                r_miss     <= 1'b1;
                r_miss_cnt <= w_miss_next;
                r_presc    <= '0;
                r_tcnt     <= '0;
                r_valid    <= 1'b0;
                if (w_miss_next == LIMIT) begin
                  r_state <= S_OVER;
                  r_leds  <= 8'h00;
                  r_over  <= 1'b1;
                end else begin
                  r_state <= S_GAP;
                  r_leds  <= 8'hFF;
                end
              end else begin
                r_state <= S_UP;
              end
            end
          end
          S_OVER: begin
            r_leds  <= 8'h00;
            r_valid <= 1'b0;
            r_over  <= 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
            r_leds  <= 8'hFF;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign LEDs         = r_leds;
  assign mole_valid   = r_valid;
  assign mole_idx     = r_mole_idx;
  assign hit_strobe   = r_hit;
  assign miss_strobe  = r_miss;
  assign wrong_strobe = r_wrong;
  assign miss_cnt     = r_miss_cnt;
  assign game_over    = r_over;

endmodule

// File: tb/tb_mole_spawner.sv
// Scoreboard bench for mole_spawner: a deadline-based game model predicts
// every strobe / mole-appearance event and the per-cycle display outputs.
module tb_mole_spawner;
  localparam int TD = 4;
  localparam int GT = 3;
  localparam int MT = 5;
  localparam int ML = 3;
  localparam logic [7:0] SEED = 8'hA5;

  logic       Clk = 1'b0;
  logic       reset = 1'b0;
  logic       EN = 1'b0;
  logic [7:0] btn_pulse = 8'h00;
  logic [7:0] LEDs;
  logic       mole_valid;
  logic [2:0] mole_idx;
  logic       hit_strobe;
  logic       miss_strobe;
  logic       wrong_strobe;
  logic [3:0] miss_cnt;
  logic       game_over;

  mole_spawner #(
    .TICK_DIV(TD), .GAP_TIME(GT), .MOLE_TIME(MT), .MISS_LIMIT(ML), .LFSR_SEED(SEED)
  ) dut (
    .Clk(Clk), .reset(reset), .EN(EN), .btn_pulse(btn_pulse),
    .LEDs(LEDs), .mole_valid(mole_valid), .mole_idx(mole_idx),
    .hit_strobe(hit_strobe), .miss_strobe(miss_strobe), .wrong_strobe(wrong_strobe),
    .miss_cnt(miss_cnt), .game_over(game_over)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_GAP, M_UP, M_OVER} mmode_t;
  // flags = {mole_appears, hit, wrong, miss, game_over_rises}
  typedef struct {
    int         cyc;
    logic [4:0] flags;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc = 0;
  bit         m_init = 1'b0;
  mmode_t     m_mode = M_IDLE;
  int         m_end = 0;
  logic [2:0] m_idx = 3'd0;
  int         m_miss = 0;
  logic [7:0] m_lfsr = SEED;
  logic [7:0] m_pre;
  logic [4:0] m_fl;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  function automatic logic [7:0] exp_leds();
    if (m_mode == M_UP) return ~(8'b0000_0001 << m_idx);
    if (m_mode == M_OVER) return 8'h00;
    return 8'hFF;
  endfunction

  initial forever begin
    @(posedge Clk);
    cyc++;
    m_pre = m_lfsr;
    m_fl = 5'b00000;
    if (!reset) begin
      m_init = 1'b1;
      m_mode = M_IDLE;
      m_idx  = 3'd0;
      m_miss = 0;
      m_lfsr = SEED;
    end else begin
      m_lfsr = lfsr_step(m_pre);
      if (!EN) begin
        m_mode = M_IDLE;
        m_miss = 0;
      end else begin
        case (m_mode)
          M_IDLE: begin
            m_mode = M_GAP;
            m_end  = cyc + GT * TD;
          end
          M_GAP: if (cyc == m_end) begin
            m_idx  = (m_pre[2:0] == m_idx) ? m_pre[2:0] + 3'd1 : m_pre[2:0];
            m_mode = M_UP;
            m_end  = cyc + MT * TD;
            m_fl[4] = 1'b1;
          end
          M_UP: begin
            if (btn_pulse[m_idx]) begin
              m_fl[3] = 1'b1;
              m_mode  = M_GAP;
              m_end   = cyc + GT * TD;
            end else begin
              if (btn_pulse != 8'h00) m_fl[2] = 1'b1;
              if (cyc == m_end) begin
                m_fl[1] = 1'b1;
                if (m_miss < ML) m_miss++;
                if (m_miss == ML) begin
                  m_mode  = M_OVER;
                  m_fl[0] = 1'b1;
                end else begin
                  m_mode = M_GAP;
                  m_end  = cyc + GT * TD;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
    if (m_fl != 5'b00000) exp_q.push_back('{cyc, m_fl});
  end

  // ---------------- monitor ----------------
  logic       prev_valid;
  logic       prev_over;
  logic [4:0] dut_fl;
  ev_t        ev;

  initial forever begin
    @(negedge Clk);
    if (m_init) begin
      chk("leds", {24'd0, LEDs}, {24'd0, exp_leds()});
      chk("mole_valid", {31'd0, mole_valid}, {31'd0, m_mode == M_UP});
      chk("mole_idx", {29'd0, mole_idx}, {29'd0, m_idx});
      chk("miss_cnt", {28'd0, miss_cnt}, m_miss);
      chk("game_over", {31'd0, game_over}, {31'd0, m_mode == M_OVER});
      dut_fl = {mole_valid & ~prev_valid, hit_strobe, wrong_strobe, miss_strobe,
                game_over & ~prev_over};
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        ev = exp_q.pop_front();
        chk("missing_event", 32'd0, {27'd0, ev.flags});
      end
      if (dut_fl != 5'b00000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {27'd0, dut_fl}, 32'd0);
        end else begin
          ev = exp_q.pop_front();
          chk("event_cycle", cyc, ev.cyc);
          chk("event_flags", {27'd0, dut_fl}, {27'd0, ev.flags});
        end
      end
    end
    prev_valid = mole_valid;
    prev_over  = game_over;
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    reset = 1'b0;
    EN = 1'b0;
    btn_pulse = 8'h00;
    @(negedge Clk);
    chk("rst_leds", {24'd0, LEDs}, 32'hFF);
    chk("rst_valid", {31'd0, mole_valid}, 32'd0);
    chk("rst_idx", {29'd0, mole_idx}, 32'd0);
    chk("rst_strobes", {29'd0, hit_strobe, miss_strobe, wrong_strobe}, 32'd0);
    chk("rst_miss_cnt", {28'd0, miss_cnt}, 32'd0);
    chk("rst_game_over", {31'd0, game_over}, 32'd0);
    reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic wait_up(input int bound, output int n);
    n = 0;
    while (!mole_valid && n < bound) begin
      @(negedge Clk);
      n++;
    end
    if (!mole_valid) chk("wait_mole_timeout", 32'd0, 32'd1);
  endtask

  int         n;
  int         k;
  int         r;
  logic [2:0] first_idx;
  logic [2:0] old_idx;
  logic [7:0] saved_leds;
  int         pct;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge Clk);
    do_reset();

    // 1: first gap length and first mole
    EN = 1'b1;
    wait_up(40, n);
    chk("s1_gap_len", n, 13);
    chk("s1_one_led_lit", $countones(~LEDs), 1);
    chk("s1_led_matches_idx", {24'd0, LEDs}, {24'd0, ~(8'b0000_0001 << mole_idx)});
    first_idx = mole_idx;

    // 2: correct hit
    old_idx = mole_idx;
    btn_pulse = 8'b0000_0001 << mole_idx;
    @(negedge Clk);
    btn_pulse = 8'h00;
    chk("s2_hit", {31'd0, hit_strobe}, 32'd1);
    chk("s2_leds_off", {24'd0, LEDs}, 32'hFF);
    chk("s2_miss_cnt", {28'd0, miss_cnt}, 32'd0);
    wait_up(40, n);
    chk("s2_regap_len", n, 12);
    chk("s2_idx_differs", {31'd0, mole_idx != old_idx}, 32'd1);

    // 3: wrong button, then timeout
    saved_leds = LEDs;
    btn_pulse = 8'b0000_0001 << ((mole_idx + 3'd1 + 3'($urandom_range(0, 6))) % 8);
    k = 0;
    @(negedge Clk);
    k++;
    btn_pulse = 8'h00;
    chk("s3_wrong", {31'd0, wrong_strobe}, 32'd1);
    chk("s3_leds_kept", {24'd0, LEDs}, {24'd0, saved_leds});
    while (!miss_strobe && k < 40) begin
      @(negedge Clk);
      k++;
    end
    chk("s3_miss_latency", k, 20);
    chk("s3_miss_cnt", {28'd0, miss_cnt}, 32'd1);

    // 4: run out of misses, OVER ignores buttons, EN drop clears
    k = 0;
    while (!game_over && k < 200) begin
      @(negedge Clk);
      k++;
    end
    chk("s4_game_over", {31'd0, game_over}, 32'd1);
    chk("s4_miss_cnt", {28'd0, miss_cnt}, 32'd3);
    chk("s4_leds_all_lit", {24'd0, LEDs}, 32'h00);
    for (int i = 0; i < 6; i++) begin
      btn_pulse = 8'($urandom);
      @(negedge Clk);
    end
    btn_pulse = 8'h00;
    chk("s4_still_over", {31'd0, game_over}, 32'd1);
    EN = 1'b0;
    @(negedge Clk);
    chk("s4_idle_miss_cnt", {28'd0, miss_cnt}, 32'd0);
    chk("s4_idle_game_over", {31'd0, game_over}, 32'd0);
    chk("s4_idle_leds", {24'd0, LEDs}, 32'hFF);
    @(negedge Clk);
    EN = 1'b1;

    // 5: hit on the timeout tick
    wait_up(40, n);
    repeat (19) @(negedge Clk);
    btn_pulse = 8'b0000_0001 << mole_idx;
    @(negedge Clk);
    btn_pulse = 8'h00;
    chk("s5_hit", {31'd0, hit_strobe}, 32'd1);
    chk("s5_no_miss", {31'd0, miss_strobe}, 32'd0);
    chk("s5_miss_cnt", {28'd0, miss_cnt}, 32'd0);

    // 6: reset mid-UP restarts the same mole sequence
    wait_up(40, n);
    repeat (3) @(negedge Clk);
    do_reset();
    EN = 1'b1;
    wait_up(40, n);
    chk("s6_gap_len", n, 13);
    chk("s6_same_first_idx", {29'd0, mole_idx}, {29'd0, first_idx});

    // Randomised play with varying hit rates and occasional EN drops
    for (int seg = 0; seg < 3; seg++) begin
      pct = (seg == 0) ? 10 : ((seg == 1) ? 3 : 0);
      for (int i = 0; i < 1000; i++) begin
        r = $urandom_range(0, 99);
        EN = (r != 0);
        if (r >= 1 && r < 1 + pct) btn_pulse = 8'b0000_0001 << m_idx;
        else if (r >= 90) btn_pulse = 8'($urandom);
        else btn_pulse = 8'h00;
        @(negedge Clk);
      end
    end

    btn_pulse = 8'h00;
    EN = 1'b0;
    repeat (3) @(negedge Clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
